inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the fetch stage and the decode stage. It accepts the fetch stage's valid/instruction stream, buffers up to DEPTH words in order, and presents them to decode with a valid/stall handshake. It drives the fetch stage's stall input and drops all buffered words when a branch flush occurs.

## Interface
- `WORD`, from `params.v`: instruction width.
- `DEPTH`, 4: number of entries; must be a power of two and at least 2.
- `PTRW`, log2(DEPTH): pointer width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `v_i`  in  1: fetch output valid.
- `inst_i`  in  WORD: fetch instruction word.
- `stall_o`  out  1: to the fetch stage's `stall_i`; high means the queue will not accept a word this cycle.
- `flush`  in  1: branch taken; discard all contents.
- `v_o`  out  1: head word valid, to decode.
- `inst_o`  out  WORD: head instruction word.
- `stall_i`  in  1: decode cannot consume this cycle.
- `count_o`  out  PTRW+1: number of occupied entries.

## Operation
- Push condition: `push = v_i & ~stall_o & ~flush`.
- Pop condition: `pop = v_o & ~stall_i & ~flush`.
- The word at the write pointer is written on push. The read pointer advances on pop.
- Pointers are PTRW bits wide and wrap naturally modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- `stall_o = (count == DEPTH)`. It is a function of registered state only. There is no combinational path from `stall_i` to `stall_o`.
- Because `stall_o` depends only on count, a full queue refuses a push even in a cycle where it also pops. The word is accepted on the next cycle.
- `v_o = (count != 0)`. `inst_o` is the entry at the read pointer.
- Flush:
  - On the next edge, count becomes 0 and both pointers reset to 0.
  - Any `v_i` word presented in the flush cycle is dropped.
  - `v_o` stays as computed during the flush cycle, but no pop occurs.
- Ordering is strict FIFO. No word is duplicated or lost except by flush.

## Timing
- Reset values: `v_o=0`, `inst_o` = the storage contents (don't-care, since `v_o=0`), `stall_o=0`, `count_o=0`, pointers = 0.
- Reset asserted mid-operation clears all state asynchronously, in the same way as flush.
- Latency without bypass: a word pushed at edge N appears on `v_o`/`inst_o` in the cycle after edge N.
- Throughput: one push and one pop per cycle, sustained whenever 0 < count < DEPTH.
- Empty queue: `v_o=0`; pop is impossible.
- Full queue: `stall_o=1`. Fetch holds its state.
- Flush while full: `stall_o` is still 1 in the flush cycle and drops to 0 after the edge.

## Configuration
- `INST_QUEUE_BYPASS_EN` defined:
  - When count == 0 and `v_i` and not `flush`: `v_o=1` and `inst_o=inst_i` combinationally.
  - If `stall_i=0` in that cycle, the word is consumed and is not written (count stays 0).
  - If `stall_i=1`, the word is written normally.
  - This adds a zero-cycle path from `inst_i` to `inst_o`.
- `INST_QUEUE_BYPASS_EN` undefined: the minimum latency is 1 cycle, as described under Timing.

## Structure
- `WORD` comes from the shared `params.v` include. Add `IQ_DEPTH` there so fetch and decode can reference the same value.
- One sub-module, `inst_queue_mem`: a DEPTH×WORD register array with one write port (`we`, `waddr`, `wdata`) and one asynchronous read port.
  - `inst_queue_mem` has no reset.
  - The pointers, count and handshake logic stay in `inst_queue`.

## Test plan
- **Reset then fill:** reset, then `v_i=1` with words 0x11, 0x22, 0x33, 0x44 and `stall_i=1`. Expect `count_o` = 1, 2, 3, 4, with `stall_o=1` after the 4th edge. A 5th word 0x55 is held and not accepted.
- **Drain in order:** from full, `stall_i=0`, `v_i=0`. Expect `inst_o` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then `v_o=0` and `count_o=0`.
- **Sustained stream:** `v_i=1` with an incrementing word each cycle, `stall_i=0`, for 20 cycles. Expect every word out exactly once, in order, at 1-cycle latency (0 with bypass), and `stall_o` never asserted.
- **Full with pop:** count=4, `v_i=1`, `stall_i=0`. Expect the pop to occur, the push to be refused, and count=3. On the next cycle the push is accepted and count stays 3.
- **Flush:** count=3 and `flush=1` with `v_i=1` carrying 0x99. Expect `count_o=0` and `v_o=0` on the next cycle, and 0x99 never to appear at the output.
- **Async reset mid-stream:** assert `reset` between edges while count=2. Expect `v_o=0` and `count_o=0` immediately, before the next edge.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared constants for the fetch/decode instruction queue.
// IQ_DEPTH lives here so fetch and decode can size against the same value as the queue.
package inst_queue_pkg;

  localparam int IQ_WORD  = 32;
  localparam int IQ_DEPTH = 4;

endpackage

// File: rtl/inst_queue_mem.sv
// DEPTH x WORD storage for the instruction queue.
// One write port and one asynchronous read port; holds no reset.
module inst_queue_mem
  import inst_queue_pkg::*;
#(
  parameter int WORD  = IQ_WORD,
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PTRW-1:0] waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [PTRW-1:0] raddr,
  output logic [WORD-1:0] rdata
);

  logic [WORD-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// In-order instruction queue between fetch and decode with branch flush.
// Optional INST_QUEUE_BYPASS_EN forwards inst_i straight to decode when the queue is empty.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int WORD  = IQ_WORD,
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  output logic            stall_o,
  input  logic            flush,
  output logic            v_o,
  output logic [WORD-1:0] inst_o,
  input  logic            stall_i,
  output logic [PTRW:0]   count_o
);

  localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW:0]   count;
  logic [WORD-1:0] mem_rdata;
  logic            push;
  logic            pop;
  logic            do_write;
  logic            do_read;
`ifdef INST_QUEUE_BYPASS_EN
  logic            bypass;
`endif

  // stall_o looks only at registered count, so a full queue refuses even while popping
  always_comb begin
    stall_o = (count == FULL);
    push    = v_i & ~stall_o & ~flush;
`ifdef INST_QUEUE_BYPASS_EN
    bypass   = (count == '0) & v_i & ~flush;
    v_o      = (count != '0) | bypass;
    inst_o   = bypass ? inst_i : mem_rdata;
    pop      = v_o & ~stall_i & ~flush;
    do_write = push & ~(bypass & ~stall_i);
    do_read  = pop & ~bypass;
`else
    v_o      = (count != '0);
    inst_o   = mem_rdata;
    pop      = v_o & ~stall_i & ~flush;
    do_write = push;
    do_read  = pop;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign count_o = count;

  inst_queue_mem #(
    .WORD  (WORD),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (inst_i),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: fill, drain, stream, full-with-pop,
// flush and asynchronous reset, with hand-computed expectations.
module tb_inst_queue;

  logic        clk;
  logic        reset;
  logic        v_i;
  logic [31:0] inst_i;
  logic        stall_o;
  logic        flush;
  logic        v_o;
  logic [31:0] inst_o;
  logic        stall_i;
  logic [2:0]  count_o;

  int tests_run;
  int tests_failed;

  inst_queue dut (
    .clk     (clk),
    .reset   (reset),
    .v_i     (v_i),
    .inst_i  (inst_i),
    .stall_o (stall_o),
    .flush   (flush),
    .v_o     (v_o),
    .inst_o  (inst_o),
    .stall_i (stall_i),
    .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] word, input logic st, input logic fl);
    v_i     = v;
    inst_i  = word;
    stall_i = st;
    flush   = fl;
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill_words [4];
  logic [31:0] exp_q [$];
  logic [31:0] head;
  int          outputs_seen;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    fill_words[0] = 32'h11;
    fill_words[1] = 32'h22;
    fill_words[2] = 32'h33;
    fill_words[3] = 32'h44;

    // reset state
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #12;
    checkOutput("reset_v_o", {31'b0, v_o}, 32'd0);
    checkOutput("reset_count", {29'b0, count_o}, 32'd0);
    checkOutput("reset_stall_o", {31'b0, stall_o}, 32'd0);
    reset = 1'b0;

    // fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fill_words[i], 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("fill_count_%0d", i), {29'b0, count_o}, 32'(i + 1));
    end
    checkOutput("fill_stall_o", {31'b0, stall_o}, 32'd1);
    checkOutput("fill_head", inst_o, 32'h11);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    tick();
    checkOutput("fill_5th_held", {29'b0, count_o}, 32'd4);
    checkOutput("fill_5th_head", inst_o, 32'h11);

    // drain in order
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_v_%0d", i), {31'b0, v_o}, 32'd1);
      checkOutput($sformatf("drain_word_%0d", i), inst_o, fill_words[i]);
      tick();
    end
    checkOutput("drain_empty_v", {31'b0, v_o}, 32'd0);
    checkOutput("drain_empty_count", {29'b0, count_o}, 32'd0);

    // full with pop: the push is refused while full, taken on the next cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA1 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    checkOutput("fwp_full_count", {29'b0, count_o}, 32'd4);
    applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
    checkOutput("fwp_stall_o", {31'b0, stall_o}, 32'd1);
    tick();
    checkOutput("fwp_count_after_pop", {29'b0, count_o}, 32'd3);
    checkOutput("fwp_head_after_pop", inst_o, 32'hA2);
    checkOutput("fwp_stall_released", {31'b0, stall_o}, 32'd0);
    tick();
    checkOutput("fwp_count_push_pop", {29'b0, count_o}, 32'd3);
    checkOutput("fwp_head_a3", inst_o, 32'hA3);

    // flush at count 3 with a word on the fetch side
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b1);
    checkOutput("flush_v_o_in_cycle", {31'b0, v_o}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_count", {29'b0, count_o}, 32'd0);
    checkOutput("flush_v_o", {31'b0, v_o}, 32'd0);
    tick();
    checkOutput("flush_no_99", {31'b0, v_o}, 32'd0);

    // sustained stream, decode never stalls
    outputs_seen = 0;
    exp_q.delete();
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        applyStimulus(1'b1, 32'h100 + 32'(c), 1'b0, 1'b0);
        exp_q.push_back(32'h100 + 32'(c));
      end else begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      end
      #1;
      checkOutput($sformatf("stream_stall_%0d", c), {31'b0, stall_o}, 32'd0);
`ifdef INST_QUEUE_BYPASS_EN
      checkOutput($sformatf("stream_v_%0d", c), {31'b0, v_o}, {31'b0, (c < 20)});
`else
      checkOutput($sformatf("stream_v_%0d", c), {31'b0, v_o}, {31'b0, (c >= 1 && c <= 20)});
`endif
      if (v_o) begin
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("stream_extra_%0d", c), inst_o, 32'hDEAD_BEEF);
        end else begin
          head = exp_q.pop_front();
          checkOutput($sformatf("stream_word_%0d", c), inst_o, head);
          outputs_seen++;
        end
      end
      tick();
    end
    checkOutput("stream_total", 32'(outputs_seen), 32'd20);

    // asynchronous reset between edges at count 2
    applyStimulus(1'b1, 32'h61, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h62, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("areset_pre_count", {29'b0, count_o}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_v_o", {31'b0, v_o}, 32'd0);
    checkOutput("areset_count", {29'b0, count_o}, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h77, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("areset_recover_count", {29'b0, count_o}, 32'd1);
    checkOutput("areset_recover_word", inst_o, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
